// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
//   in_valid/in_ready   : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf)
// master = producer of operands / consumer of results; slave = the adder.
interface pipe_adder_if #(
   parameter int unsigned N = 16
) ();
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: N-bit add/subtract split into STAGES carry-chain segments of W = N/STAGES bits,
// one segment per pipeline stage, with valid/ready on both sides.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears valids and the visible result)
//   bus   : pipe_adder_if.slave (operands in, sum/cout/ovf out)
// sub=1 computes a - b (cin ignored, cout=1 means no borrow); sub=0 computes a + b + cin.
// A single global advance enable shifts every stage at once; bubbles are kept.
module pipe_adder #(
   parameter int unsigned N      = 16,
   parameter int unsigned STAGES = 4
) (
   input logic         clk,
   input logic         rst_n,
   pipe_adder_if.slave bus
);

   if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_stages
      $error("pipe_adder: STAGES must lie in 1..N and divide N exactly");
   end

   if ($bits(bus.a) != N) begin : g_bad_width
      $error("pipe_adder: interface width does not match N");
   end

   // Guarded so an illegal STAGES=0 reports the message above rather than a divide by zero.
   localparam int unsigned W = (STAGES == 0) ? 1 : N / STAGES;

   // Per-stage registers: operands travel whole (upper chunks are consumed by later stages),
   // the partial sum accumulates completed low chunks, c_q is the carry into the next stage.
   logic [N-1:0]      a_q [STAGES];
   logic [N-1:0]      b_q [STAGES];
   logic [N-1:0]      s_q [STAGES];
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] v_q;

   logic [N-1:0]      a_d [STAGES];
   logic [N-1:0]      b_d [STAGES];
   logic [N-1:0]      s_d [STAGES];
   logic [STAGES-1:0] c_d;
   logic [STAGES-1:0] ci;
   logic [W:0]        part;
   logic              adv;

   // Stall only when a result is sitting at the output and nobody takes it.
   assign adv          = !v_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready = adv;

   always_comb begin
      part   = '0;
      c_d    = '0;
      // Stage 0 works on the freshly presented operands after sub preprocessing.
      a_d[0] = bus.a;
      b_d[0] = bus.sub ? ~bus.b : bus.b;
      s_d[0] = '0;
      ci[0]  = bus.sub ? 1'b1 : bus.cin;
      for (int k = 1; k < STAGES; k++) begin
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
         s_d[k] = s_q[k-1];
         ci[k]  = c_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part = {1'b0, a_d[k][k*W +: W]} + {1'b0, b_d[k][k*W +: W]} + {{W{1'b0}}, ci[k]};
         s_d[k][k*W +: W] = part[W-1:0];
         c_d[k]           = part[W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // Data is cleared too so the output reads as zero (including ovf) after reset.
         v_q <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (adv) begin
         v_q[0] <= bus.in_valid;
         for (int k = 1; k < STAGES; k++) begin
            v_q[k] <= v_q[k-1];
         end
         c_q <= c_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
      end
   end

   assign bus.out_valid = v_q[STAGES-1];
   assign bus.sum       = s_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   // Operands with equal signs producing a result of the other sign.
   assign bus.ovf       = (a_q[STAGES-1][N-1] == b_q[STAGES-1][N-1]) &&
                          (s_q[STAGES-1][N-1] != a_q[STAGES-1][N-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: self-checking bench for pipe_adder.
// Directed add/sub cases with latency checks, a randomized backpressure run against an
// arithmetic reference model, and a mid-flight reset flush.
module tb_pipe_adder #(
   parameter int unsigned N      = 16,
   parameter int unsigned STAGES = 4
);

   typedef struct packed {
      logic         ovf;
      logic         cout;
      logic [N-1:0] sum;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   pipe_adder_if #(.N(N)) bus ();

   pipe_adder #(.N(N), .STAGES(STAGES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic cin, input logic sub);
      longint u;
      longint s;
      longint lim;
      res_t   r;
      lim = longint'(1) << (N - 1);
      if (sub) begin
         u      = longint'(a) - longint'(b);
         s      = longint'($signed(a)) - longint'($signed(b));
         r.cout = (a >= b);
      end else begin
         u      = longint'(a) + longint'(b) + longint'(cin);
         s      = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
         r.cout = (u >= (longint'(1) << N));
      end
      r.sum = u[N-1:0];
      r.ovf = (s >= lim) || (s < -lim);
      return r;
   endfunction

   task automatic run_one(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic sub, input logic [N-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
      int   lat;
      logic found;
      @(negedge clk);
      bus.a         = a;
      bus.b         = b;
      bus.cin       = cin;
      bus.sub       = sub;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      lat   = 0;
      found = 1'b0;
      for (int i = 1; i <= 40 && !found; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         #1;
         if (bus.out_valid) begin
            found = 1'b1;
            lat   = i;
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'(STAGES));
      check({tag, "_sum"}, 64'(bus.sum), 64'(exp_sum));
      check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
      check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
      @(negedge clk);
      #1;
      check({tag, "_no_dup"}, 64'(bus.out_valid), 64'(0));
   endtask

   initial begin : main
      int   sent;
      int   got;
      int   seen;
      logic stalled;
      res_t held;
      res_t r;
      res_t e;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_sum", 64'(bus.sum), 64'(0));
      check("rst_cout", 64'(bus.cout), 64'(0));
      check("rst_ovf", 64'(bus.ovf), 64'(0));
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));
      rst_n = 1'b1;

      run_one("add_carry8", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("add_cin",    16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
      run_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Random back-to-back beats under random backpressure.
      sent    = 0;
      got     = 0;
      stalled = 1'b0;
      held    = '0;
      for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
         @(negedge clk);
         bus.in_valid  = (sent < 20);
         bus.a         = N'($urandom);
         bus.b         = N'($urandom);
         bus.cin       = 1'($urandom);
         bus.sub       = 1'($urandom);
         bus.out_ready = 1'($urandom);
         #1;
         r = {bus.ovf, bus.cout, bus.sum};
         check("rand_in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
         if (stalled) begin
            check("rand_hold_valid", 64'(bus.out_valid), 64'(1));
            check("rand_hold_data", 64'(r), 64'(held));
         end
         if (bus.out_valid && bus.out_ready) begin
            check("rand_expected_pending", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rand_result", 64'(r), 64'(e));
            end
            got++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held    = r;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            sent++;
         end
      end
      check("rand_count", 64'(got), 64'(20));
      check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

      // Three beats in flight, then a one-cycle reset must discard them.
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (STAGES + 2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.a        = N'(16'h0100 + i);
         bus.b        = N'(16'h0011);
         bus.cin      = 1'b0;
         bus.sub      = 1'b0;
         bus.in_valid = 1'b1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      #1;
      check("flush_in_ready_in_reset", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;
      check("flush_valid_at_reset", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < STAGES + 6; i++) begin
         @(negedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check("flush_no_stale_results", 64'(seen), 64'(0));
      run_one("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- N-bit adder/subtractor pipelined over STAGES carry-chain segments, each W = N/STAGES bits wide.
- Supports carry-in, subtract mode, carry-out and signed overflow.
- Uses valid/ready handshakes on input and output.
- Successor to the combinational per-bit adder arrays; used wherever wide adds must close timing at full clock rate with backpressure.

Parameters:
- N, 16, operand/result width in bits.
- STAGES, 4, number of pipeline segments. Must divide N exactly; 1 <= STAGES <= N. Illegal values cause elaboration failure.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in. Used only when sub=0.
- sub  input  1  1 = compute a - b; 0 = compute a + b + cin.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  N  result.
- cout  output  1  carry-out of MSB. In sub mode, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0. Operand/partial-sum registers need not reset. in_ready=1 during and after reset. Reset mid-flight discards all in-flight beats; no result emerges for them.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid, sum, cout and ovf hold stable while out_valid && !out_ready.
- Advance rule: one global enable, adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid/out_ready only, never from in_valid.
  - When adv=1, every stage shifts one place. Stage 0 captures the input beat, and its valid bit = in_valid.
  - When adv=0, all stages hold.
  - Bubbles are not collapsed.
- Operand preprocessing at capture:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage k (0..STAGES-1):
  - Adds bits [k*W +: W] of a and b_eff, plus the carry from stage k-1 (c0 for k=0), using a (W+1)-bit sum.
  - Registers the W result bits and the carry.
  - Higher operand chunks are skewed forward through delay registers; lower result chunks are delayed to align at the output.
- Latency: STAGES cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle when out_ready=1.
- Output:
  - sum = concatenated aligned chunks.
  - cout = final stage carry.
  - ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]), with the operand MSBs delayed to the output stage.
- Ordering: results leave in acceptance order; no loss, no duplication.
- STAGES=1: single register stage, latency 1, identical handshake.
- STAGES=N (W=1): per-bit ripple pipeline, latency N.
- Simultaneous input and output transfer in the same cycle is legal and sustains full throughput.

Test Plan (N=16, STAGES=4 unless stated):
- Reset, then a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> out_valid rises exactly 4 cycles after the input transfer. sum=0x0100, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x0000, cin=1 -> sum=0x1235.
- sub=1: a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored). Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- 20 back-to-back random beats with out_ready driven by a random 50% pattern -> in_ready == (!out_valid || out_ready) every cycle. Outputs hold while stalled. All 20 results match a reference model, in order, each exactly once.
- Three beats in flight, then rst_n=0 for 1 cycle, then release -> out_valid=0 from the reset edge. None of the three results ever appears. A new beat 0x0001+0x0001 yields 0x0002 after 4 cycles.
- Re-elaborate with STAGES=1 and STAGES=16 -> the first two scenarios pass with latency 1 and 16 respectively. STAGES=3 with N=16 fails elaboration.
